alu_wb_stage: RTL

//  Writeback stage directly downstream of the combinational ALU. Registers Out/Zero plus

---
 rtl/alu_wb_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// Writeback stage: 2-entry skid buffer between the ALU and the register-file write port,
// plus the committed Zero flag. Optional zero-latency bypass when WB_BYPASS_EN is defined.
module alu_wb_stage #(
  parameter int W        = 8,
  parameter int RegAddrW = 3
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                InValid,
  output logic                InReady,
  input  logic [W-1:0]        AluOut,
  input  logic                AluZero,
  input  logic [RegAddrW-1:0] DestReg,
  input  logic                WrEn,
  input  logic                SetFlag,
  input  logic                Flush,
  output logic                WbValid,
  input  logic                WbReady,
  output logic [W-1:0]        WbData,
  output logic [RegAddrW-1:0] WbReg,
  output logic                WbWrEn,
  output logic                FlagZero
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [W-1:0]        data;
    logic                zero;
    logic [RegAddrW-1:0] dest;
    logic                wr_en;
    logic                set_flag;
  } entry_t;

  state_e state_q, state_d;
  logic   rd_ptr_q, rd_ptr_d;
  logic   wr_ptr_q, wr_ptr_d;
  entry_t mem_q [2];
  entry_t mem_d [2];
  logic   flag_q, flag_d;

  entry_t in_entry, head, out_entry;
  logic   push, pop, bypass, wb_valid;

  assign in_entry = '{data: AluOut, zero: AluZero, dest: DestReg, wr_en: WrEn, set_flag: SetFlag};
  assign head     = mem_q[rd_ptr_q];

  // InReady comes only from registered state, so WbReady never reaches it combinationally.
  always_comb begin
    InReady = (state_q != FULL);
    push    = InValid & InReady;
`ifdef WB_BYPASS_EN
    bypass  = (state_q == EMPTY) & InValid & WbReady & ~Flush;
`else
    bypass  = 1'b0;
`endif
    out_entry = bypass ? in_entry : head;
    wb_valid  = (state_q != EMPTY) | bypass;
    pop       = wb_valid & WbReady;
  end

  assign WbValid  = wb_valid;
  assign WbData   = out_entry.data;
  assign WbReg    = out_entry.dest;
  assign WbWrEn   = out_entry.wr_en & wb_valid;
  assign FlagZero = flag_q;

  // Flush wins over everything; a bypassed entry commits its flag without being stored.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    flag_d   = flag_q;
    if (Flush) begin
      state_d  = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else if (bypass) begin
      if (in_entry.set_flag) flag_d = in_entry.zero;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head.set_flag) flag_d = head.zero;
      end
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
      flag_q   <= flag_d;
    end
  end

endmodule
